// File: rtl/flit_inject_ni_pkg.sv
// Shared definitions for the NI injection stage: flit type coding, type-field
// position and packet FSM state encoding.
package flit_inject_ni_pkg;

  localparam int TYPE_HI = 19;
  localparam int TYPE_LO = 18;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pkt_state_e;

  function automatic flit_type_e flit_type(input logic [TYPE_HI:0] flit);
    return flit_type_e'(flit[TYPE_HI:TYPE_LO]);
  endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO with a combinational head read. The caller guarantees no
// push while full (unless popping) and no pop while empty.
module ni_sync_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/flit_inject_ni.sv
// NI injection stage: buffers the unstallable trace flit stream, forwards it to
// the router under credit flow control, and polices head/body/tail framing.
module flit_inject_ni
  import flit_inject_ni_pkg::*;
#(
  parameter int FLIT_W     = 20,
  parameter int FIFO_DEPTH = 32,
  parameter int CREDITS    = 4
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [FLIT_W-1:0]             in_flit,
  input  logic                          in_valid,
  output logic [FLIT_W-1:0]             out_flit,
  output logic                          out_valid,
  input  logic                          credit_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    pkt_cnt,
  output logic                          overflow,
  output logic                          fmt_err,
  output logic                          credit_err,
  output logic                          busy
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [FLIT_W-1:0] head_flit;
  logic              fifo_full, fifo_empty;
  logic              push, pop, fwd, discard, legal;
  flit_type_e        head_type;

  pkt_state_e        state_q, state_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              fmt_err_q, fmt_err_d;
  logic              credit_err_q, credit_err_d;

  ni_sync_fifo #(
    .W     (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .push  (push),
    .wdata (in_flit),
    .pop   (pop),
    .rdata (head_flit),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    head_type = flit_type(head_flit[TYPE_HI:0]);
    legal     = (state_q == ST_ACTIVE) || (head_type == FT_HEAD) || (head_type == FT_SINGLE);
    fwd       = !fifo_empty && legal && (credits_q != '0);
    discard   = !fifo_empty && !legal;
    pop       = fwd || discard;
    // A full FIFO still accepts the write when the head leaves on the same edge.
    push      = in_valid && (!fifo_full || pop);

    state_d      = state_q;
    pkt_cnt_d    = pkt_cnt_q;
    out_flit_d   = out_flit_q;
    out_valid_d  = fwd;
    overflow_d   = overflow_q || (in_valid && !push);
    fmt_err_d    = fmt_err_q || discard;
    credit_err_d = credit_err_q;
    credits_d    = credits_q;

    if (fwd) begin
      out_flit_d = head_flit;
      case (head_type)
        FT_HEAD: begin
          if (state_q == ST_ACTIVE) fmt_err_d = 1'b1;
          state_d = ST_ACTIVE;
        end
        FT_TAIL: begin
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + 8'd1;
        end
        FT_SINGLE: begin
          if (state_q == ST_ACTIVE) fmt_err_d = 1'b1;
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + 8'd1;
        end
        default: state_d = state_q;
      endcase
    end

    // A returned credit and a consumed credit in the same cycle cancel out.
    if (fwd && !credit_in) begin
      credits_d = credits_q - CW'(1);
    end else if (!fwd && credit_in) begin
      if (credits_q == CW'(CREDITS)) credit_err_d = 1'b1;
      else                           credits_d    = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      credits_q    <= CW'(CREDITS);
      pkt_cnt_q    <= '0;
      out_flit_q   <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      fmt_err_q    <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      pkt_cnt_q    <= pkt_cnt_d;
      out_flit_q   <= out_flit_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      fmt_err_q    <= fmt_err_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign out_flit   = out_flit_q;
  assign out_valid  = out_valid_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign overflow   = overflow_q;
  assign fmt_err    = fmt_err_q;
  assign credit_err = credit_err_q;
  assign busy       = !fifo_empty || (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_flit_inject_ni.sv
// Scoreboard bench for flit_inject_ni: a queue-based reference model predicts
// forwarded flits and status; a monitor compares them on the falling edge.
module tb_flit_inject_ni;

  localparam int DEPTH = 32;
  localparam int CRED  = 4;
  localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_SINGLE = 2'b11;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [19:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        credit_in = 1'b0;
  logic [19:0] out_flit;
  logic        out_valid;
  logic [5:0]  fifo_count;
  logic [7:0]  pkt_cnt;
  logic        overflow, fmt_err, credit_err, busy;

  flit_inject_ni #(.FLIT_W(20), .FIFO_DEPTH(DEPTH), .CREDITS(CRED)) dut (
    .clk        (clk),
    .RST        (RST),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .credit_in  (credit_in),
    .fifo_count (fifo_count),
    .pkt_cnt    (pkt_cnt),
    .overflow   (overflow),
    .fmt_err    (fmt_err),
    .credit_err (credit_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a plain queue for the FIFO, an in-packet flag and counters.
  logic [19:0] m_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] out_log[$];
  int          m_credits = CRED;
  bit          m_in_pkt  = 0;
  int          m_pkt     = 0;
  bit          m_ovf = 0, m_fmt = 0, m_cerr = 0;
  int          edge_n = 0;
  int          first_edge = -1;

  always @(posedge clk) edge_n++;

  always @(posedge clk or negedge RST) begin : ref_model
    int          pre_size;
    bit          popped, fwd;
    logic [19:0] f;
    logic [1:0]  t;
    if (!RST) begin
      m_q.delete();
      exp_q.delete();
      m_credits = CRED;
      m_in_pkt  = 0;
      m_pkt     = 0;
      m_ovf     = 0;
      m_fmt     = 0;
      m_cerr    = 0;
    end else begin
      pre_size = m_q.size();
      popped   = 0;
      fwd      = 0;
      if (pre_size > 0) begin
        f = m_q[0];
        t = f[19:18];
        if (!m_in_pkt && (t == T_BODY || t == T_TAIL)) begin
          void'(m_q.pop_front());
          popped = 1;
          m_fmt  = 1;
        end else if (m_credits > 0) begin
          void'(m_q.pop_front());
          popped = 1;
          fwd    = 1;
          exp_q.push_back(f);
          if (t == T_HEAD) begin
            if (m_in_pkt) m_fmt = 1;
            m_in_pkt = 1;
          end else if (t == T_TAIL) begin
            m_in_pkt = 0;
            m_pkt    = (m_pkt + 1) % 256;
          end else if (t == T_SINGLE) begin
            if (m_in_pkt) m_fmt = 1;
            m_in_pkt = 0;
            m_pkt    = (m_pkt + 1) % 256;
          end
        end
      end
      if (in_valid) begin
        if (pre_size < DEPTH || popped) m_q.push_back(in_flit);
        else m_ovf = 1;
      end
      if (fwd && !credit_in) m_credits--;
      else if (!fwd && credit_in) begin
        if (m_credits == CRED) m_cerr = 1;
        else m_credits++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [19:0] e;
    if (RST) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_flit", 32'(out_flit), 32'(e));
        end
        out_log.push_back(out_flit);
        if (first_edge < 0) first_edge = edge_n;
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end else begin
      check("out_valid_in_reset", 32'(out_valid), 32'(0));
    end
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("pkt_cnt",    32'(pkt_cnt),    32'(m_pkt));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("fmt_err",    32'(fmt_err),    32'(m_fmt));
    check("credit_err", 32'(credit_err), 32'(m_cerr));
    check("busy",       32'(busy),       32'((m_q.size() != 0) || m_in_pkt));
  end

  // Stimulus helpers: one call drives one cycle of inputs on the falling edge.
  bit         echo_en = 0;
  logic [2:0] echo_sr = '0;

  task automatic cyc(input logic v, input logic [19:0] f, input logic c);
    @(negedge clk);
    echo_sr   = {echo_sr[1:0], out_valid};
    in_valid  = v;
    in_flit   = f;
    credit_in = echo_en ? echo_sr[2] : c;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 20'h0, 1'b0);
  endtask

  task automatic pulse_credits(input int n);
    repeat (n) cyc(1'b0, 20'h0, 1'b1);
  endtask

  task automatic send_singles(input int n, input logic [17:0] base);
    for (int i = 0; i < n; i++) cyc(1'b1, {T_SINGLE, base + 18'(i)}, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    RST       = 1'b0;
    in_valid  = 1'b0;
    credit_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid",  32'(out_valid),  32'(0));
    check("rst_out_flit",   32'(out_flit),   32'(0));
    check("rst_fifo_count", 32'(fifo_count), 32'(0));
    check("rst_pkt_cnt",    32'(pkt_cnt),    32'(0));
    check("rst_flags",      32'({overflow, fmt_err, credit_err}), 32'(0));
    check("rst_busy",       32'(busy),       32'(0));
    @(posedge clk);
    #2;
    RST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int head_edge;
    logic [19:0] last_body;

    // Basic packet with echoed credits, latency check.
    do_reset();
    echo_en = 1;
    echo_sr = '0;
    base = out_log.size();
    first_edge = -1;
    cyc(1'b1, 20'h8_0001, 1'b0);
    head_edge = edge_n + 1;
    cyc(1'b1, 20'h0_0002, 1'b0);
    cyc(1'b1, 20'h4_0003, 1'b0);
    idle(12);
    echo_en = 0;
    echo_sr = '0;
    check("t1_count",   32'(out_log.size() - base), 32'(3));
    check("t1_flit0",   32'(out_log[base]),     32'h8_0001);
    check("t1_flit1",   32'(out_log[base + 1]), 32'h0_0002);
    check("t1_flit2",   32'(out_log[base + 2]), 32'h4_0003);
    check("t1_latency", 32'(first_edge - head_edge), 32'(1));
    check("t1_pkt_cnt", 32'(pkt_cnt), 32'(1));
    check("t1_flags",   32'({overflow, fmt_err, credit_err}), 32'(0));

    // 30-flit packet, no credits returned until later.
    do_reset();
    base = out_log.size();
    cyc(1'b1, {T_HEAD, 18'h100}, 1'b0);
    for (int i = 0; i < 28; i++) cyc(1'b1, {T_BODY, 18'h101 + 18'(i)}, 1'b0);
    cyc(1'b1, {T_TAIL, 18'h1FF}, 1'b0);
    idle(10);
    check("t2_fwd_before",  32'(out_log.size() - base), 32'(4));
    check("t2_fifo_count",  32'(fifo_count), 32'(26));
    pulse_credits(26);
    idle(10);
    check("t2_fwd_after",   32'(out_log.size() - base), 32'(30));
    check("t2_last",        32'(out_log[out_log.size() - 1]), {12'h0, T_TAIL, 18'h1FF});
    check("t2_pkt_cnt",     32'(pkt_cnt), 32'(1));

    // Overflow on the 33rd flit with credits exhausted.
    do_reset();
    send_singles(4, 18'h200);
    idle(6);
    base = out_log.size();
    cyc(1'b1, {T_HEAD, 18'h300}, 1'b0);
    for (int i = 0; i < 31; i++) cyc(1'b1, {T_BODY, 18'h301 + 18'(i)}, 1'b0);
    last_body = {T_BODY, 18'h301 + 18'(30)};
    cyc(1'b1, {T_TAIL, 18'h3FF}, 1'b0);
    idle(2);
    check("t3_fifo_full", 32'(fifo_count), 32'(32));
    check("t3_overflow",  32'(overflow),   32'(1));
    pulse_credits(32);
    idle(10);
    check("t3_fwd",       32'(out_log.size() - base), 32'(32));
    check("t3_last",      32'(out_log[out_log.size() - 1]), 32'(last_body));

    // Stray BODY in IDLE is discarded without using a credit.
    do_reset();
    base = out_log.size();
    cyc(1'b1, 20'h0_00AA, 1'b0);
    cyc(1'b1, 20'hC_00BB, 1'b0);
    idle(6);
    check("t4_fmt_err", 32'(fmt_err), 32'(1));
    check("t4_fwd",     32'(out_log.size() - base), 32'(1));
    check("t4_flit",    32'(out_log[out_log.size() - 1]), 32'hC_00BB);
    check("t4_pkt_cnt", 32'(pkt_cnt), 32'(1));
    send_singles(4, 18'h400);
    idle(6);
    check("t4_credit_kept", 32'(fifo_count), 32'(1));

    // Simultaneous credit return and forward at credits=1.
    do_reset();
    send_singles(3, 18'h500);
    idle(5);
    base = out_log.size();
    cyc(1'b1, {T_SINGLE, 18'h510}, 1'b0);
    cyc(1'b0, 20'h0, 1'b1);
    idle(3);
    send_singles(2, 18'h520);
    idle(5);
    check("t5_fwd",       32'(out_log.size() - base), 32'(2));
    check("t5_fifo",      32'(fifo_count), 32'(1));
    check("t5_no_cerr",   32'(credit_err), 32'(0));

    // Credit return at full credits.
    do_reset();
    idle(2);
    cyc(1'b0, 20'h0, 1'b1);
    idle(2);
    check("t5_credit_err", 32'(credit_err), 32'(1));
    send_singles(5, 18'h530);
    idle(8);
    check("t5_credits_4",  32'(fifo_count), 32'(1));

    // Reset while a packet is in flight.
    do_reset();
    base = out_log.size();
    cyc(1'b1, {T_HEAD, 18'h600}, 1'b0);
    for (int i = 0; i < 13; i++) cyc(1'b1, {T_BODY, 18'h601 + 18'(i)}, 1'b0);
    idle(8);
    check("t6_fwd",  32'(out_log.size() - base), 32'(4));
    check("t6_fifo", 32'(fifo_count), 32'(10));
    check("t6_busy", 32'(busy), 32'(1));
    do_reset();
    cyc(1'b1, 20'hC_0ABC, 1'b0);
    idle(5);
    check("t6_after",   32'(out_log[out_log.size() - 1]), 32'hC_0ABC);
    check("t6_pkt_cnt", 32'(pkt_cnt), 32'(1));
    check("t6_idle",    32'(busy), 32'(0));

    // Randomized traffic with starve phases to exercise overflow.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic       v, c;
      logic [1:0] t;
      bit         starve;
      starve = ((i / 150) % 3) == 2;
      v = ($urandom_range(0, 9) < 7);
      t = 2'($urandom_range(0, 3));
      c = starve ? 1'b0 : 1'($urandom_range(0, 1));
      cyc(v, {t, 18'($urandom)}, c);
    end
    pulse_credits(80);
    idle(5);
    check("rand_drained", 32'(fifo_count), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
